k12a_wake_gen: RTL

- Upstream stage of the k12a CPU core: generates its 8-bit wake_sources vector from raw board events.
- Synchronizes and debounces push-buttons, detects GPIO input changes and external IRQ edges, and runs a periodic timer.
- Latches each enabled event as a sticky pending flag, which stays set until the CPU leaves the halt state.

---
 rtl/k12a_wake_gen.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/k12a_wake_gen.sv
// Wake-source generator for the k12a core: turns raw board events into sticky,
// individually enabled pending flags that drop when the CPU leaves halt.
module k12a_wake_gen #(
    parameter int DEBOUNCE_CYCLES = 1024,
    parameter int TIMER_PERIOD    = 50000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       halted,
    input  logic [3:0] buttons,
    input  logic [7:0] gpio_in,
    input  logic       ext_irq,
    input  logic [7:0] enable_mask,
    output logic [7:0] wake_sources,
    output logic       timer_tick
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TM_W = $clog2(TIMER_PERIOD);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TM_W-1:0] TM_LAST = TM_W'(TIMER_PERIOD - 1);

    // ------------------------------------------------------------------
    // Two-flop synchronizers for every asynchronous input
    // ------------------------------------------------------------------
    logic [3:0] btn_meta_reg;
    logic [3:0] btn_sync_reg;
    logic [7:0] gpio_meta_reg;
    logic [7:0] gpio_sync_reg;
    logic       irq_meta_reg;
    logic       irq_sync_reg;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            btn_meta_reg  <= '0;
            btn_sync_reg  <= '0;
            gpio_meta_reg <= '0;
            gpio_sync_reg <= '0;
            irq_meta_reg  <= 1'b0;
            irq_sync_reg  <= 1'b0;
        end else begin
            btn_meta_reg  <= buttons;
            btn_sync_reg  <= btn_meta_reg;
            gpio_meta_reg <= gpio_in;
            gpio_sync_reg <= gpio_meta_reg;
            irq_meta_reg  <= ext_irq;
            irq_sync_reg  <= irq_meta_reg;
        end
    end

    // ------------------------------------------------------------------
    // Per-button debounce: a level is accepted only after it differs from
    // the stable level for DEBOUNCE_CYCLES consecutive cycles.
    // ------------------------------------------------------------------
    logic [3:0] stable_vec;
    logic [3:0] stable_d_reg;
    logic [3:0] press_event;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_debounce
            logic [DB_W-1:0] count_reg;
            logic            stable_reg;

            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    count_reg  <= '0;
                    stable_reg <= 1'b0;
                end else if (btn_sync_reg[gi] == stable_reg) begin
                    count_reg <= '0;
                end else if (count_reg == DB_LAST) begin
                    stable_reg <= btn_sync_reg[gi];
                    count_reg  <= '0;
                end else begin
                    count_reg <= count_reg + DB_W'(1);
                end
            end

            assign stable_vec[gi]  = stable_reg;
            // Only the rising edge of the debounced level is a wake event.
            assign press_event[gi] = stable_reg & ~stable_d_reg[gi];
        end
    endgenerate

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stable_d_reg <= '0;
        end else begin
            stable_d_reg <= stable_vec;
        end
    end

    // ------------------------------------------------------------------
    // Free-running periodic timer, independent of the halt state
    // ------------------------------------------------------------------
    logic [TM_W-1:0] tm_count_reg;
    logic            timer_tick_reg;
    logic            timer_event;

    assign timer_event = (tm_count_reg == TM_LAST);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tm_count_reg   <= '0;
            timer_tick_reg <= 1'b0;
        end else begin
            timer_tick_reg <= timer_event;
            tm_count_reg   <= timer_event ? '0 : tm_count_reg + TM_W'(1);
        end
    end

    assign timer_tick = timer_tick_reg;

    // ------------------------------------------------------------------
    // GPIO change and external IRQ rising-edge detectors (registered)
    // ------------------------------------------------------------------
    logic [7:0] gpio_prev_reg;
    logic [1:0] arm_reg;
    logic       gpio_event_reg;
    logic       irq_prev_reg;
    logic       irq_event_reg;
    logic       armed;

    // The synchronizers restart from zero, so the first real sample of a
    // static non-zero GPIO bus looks like a change; hold off until settled.
    assign armed = (arm_reg == 2'd3);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            gpio_prev_reg  <= '0;
            arm_reg        <= '0;
            gpio_event_reg <= 1'b0;
            irq_prev_reg   <= 1'b0;
            irq_event_reg  <= 1'b0;
        end else begin
            arm_reg        <= armed ? arm_reg : arm_reg + 2'd1;
            gpio_prev_reg  <= gpio_sync_reg;
            gpio_event_reg <= armed & (|(gpio_sync_reg ^ gpio_prev_reg));
            irq_prev_reg   <= irq_sync_reg;
            irq_event_reg  <= irq_sync_reg & ~irq_prev_reg;
        end
    end

    // ------------------------------------------------------------------
    // Event staging and sticky pending flags
    // ------------------------------------------------------------------
    logic [7:0] event_vec;
    logic [7:0] event_reg;
    logic       halted_d_reg;
    logic       wake_clear;
    logic [7:0] pending_reg;
    logic [7:0] pending_next;

    assign event_vec = {irq_event_reg, 1'b0, gpio_event_reg, timer_event, press_event};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            event_reg    <= '0;
            halted_d_reg <= 1'b0;
        end else begin
            event_reg    <= event_vec;
            halted_d_reg <= halted;
        end
    end

    assign wake_clear = halted_d_reg & ~halted;

    // Mask clear dominates; a new event wins over the halt-exit clear.
    generate
        for (gi = 0; gi < 8; gi++) begin : g_pending
            assign pending_next[gi] = !enable_mask[gi] ? 1'b0 :
                                      event_reg[gi]    ? 1'b1 :
                                      wake_clear       ? 1'b0 :
                                                         pending_reg[gi];
        end
    endgenerate

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pending_reg <= '0;
        end else begin
            pending_reg <= pending_next;
        end
    end

    assign wake_sources = pending_reg;

endmodule
